// File: rtl/counter_ctrl_panel.sv
// Push-button front end for the 4-bit universal counter: sync, debounce, press-to-toggle controls, tc and decimal-error flags.
// A clean button rise reaches its output on edge 2 + DEBOUNCE_CYCLES + 1; tc and dec_err are one cycle behind count.
module counter_ctrl_panel #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_clear,
  input  logic       btn_mode,
  input  logic       btn_dir,
  input  logic       btn_pause,
  input  logic [3:0] count,
  output logic       clear,
  output logic       mode,
  output logic       incr,
  output logic       pause,
  output logic       tc,
  output logic       dec_err
);

  typedef enum logic [1:0] {IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW} db_state_t;

  localparam logic [7:0] LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic [3:0] raw;
  logic [3:0] press;
  logic       terminal;

  // bit order: 0 clear, 1 mode, 2 dir, 3 pause
  assign raw = {btn_pause, btn_dir, btn_mode, btn_clear};

  for (genvar g = 0; g < 4; g++) begin : g_btn
    logic      meta;
    logic      sync;
    db_state_t state;
    db_state_t state_nxt;
    logic [7:0] cnt;
    logic [7:0] cnt_nxt;
    logic      evt;
    logic      evt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        meta  <= 1'b0;
        sync  <= 1'b0;
        state <= IDLE_LOW;
        cnt   <= 8'd0;
        evt   <= 1'b0;
      end else begin
        meta  <= raw[g];
        sync  <= meta;
        state <= state_nxt;
        cnt   <= cnt_nxt;
        evt   <= evt_nxt;
      end
    end

    always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      evt_nxt   = 1'b0;
      unique case (state)
        IDLE_LOW: begin
          if (sync) begin
            state_nxt = WAIT_HIGH;
            cnt_nxt   = 8'd1;
          end
        end
        WAIT_HIGH: begin
          if (!sync) begin
            state_nxt = IDLE_LOW;
            cnt_nxt   = 8'd0;
          end else if (cnt == LAST) begin
            state_nxt = IDLE_HIGH;
            cnt_nxt   = 8'd0;
            evt_nxt   = 1'b1;
          end else begin
            cnt_nxt = cnt + 8'd1;
          end
        end
        IDLE_HIGH: begin
          if (!sync) begin
            state_nxt = WAIT_LOW;
            cnt_nxt   = 8'd1;
          end
        end
        WAIT_LOW: begin
          if (sync) begin
            state_nxt = IDLE_HIGH;
            cnt_nxt   = 8'd0;
          end else if (cnt == LAST) begin
            state_nxt = IDLE_LOW;
            cnt_nxt   = 8'd0;
          end else begin
            cnt_nxt = cnt + 8'd1;
          end
        end
      endcase
    end

    assign press[g] = evt;
  end

  // Counter wraps on the next edge when this holds
  always_comb begin
    terminal = 1'b0;
    if (incr) terminal = mode ? (count == 4'd15) : (count == 4'd9);
    else      terminal = (count == 4'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clear   <= 1'b0;
      mode    <= 1'b0;
      incr    <= 1'b1;
      pause   <= 1'b0;
      tc      <= 1'b0;
      dec_err <= 1'b0;
    end else begin
      clear   <= press[0];
      mode    <= mode ^ press[1];
      incr    <= incr ^ press[2];
      pause   <= pause ^ press[3];
      tc      <= ~pause & ~clear & terminal;
      dec_err <= press[0] ? 1'b0 : (dec_err | (~mode & (count > 4'd9)));
    end
  end

endmodule
